ram_arbiter_2p: RTL and testbench

//  Two-requester arbiter/sequencer for the single-port 4Kx32 byte-writable SRAM.

---
 rtl/ram_arbiter_2p.sv | 105 ++++++++++
 tb/tb_ram_arbiter_2p.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2p.sv
// Two-port arbiter in front of a single-port byte-writable SRAM: round-robin with burst cap (or fixed priority),
// combinational grant, read data routed back to the granted port one cycle later.
module ram_arbiter_2p #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int BURST     = 2,
    parameter int FIXED_PRI = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            p0_req,
    input  logic [DW/8-1:0] p0_we,
    input  logic [AW-1:0]   p0_addr,
    input  logic [DW-1:0]   p0_wdata,
    output logic            p0_gnt,
    output logic            p0_rvalid,
    output logic [DW-1:0]   p0_rdata,
    input  logic            p1_req,
    input  logic [DW/8-1:0] p1_we,
    input  logic [AW-1:0]   p1_addr,
    input  logic [DW-1:0]   p1_wdata,
    output logic            p1_gnt,
    output logic            p1_rvalid,
    output logic [DW-1:0]   p1_rdata,
    output logic            ram_en,
    output logic [DW/8-1:0] ram_we,
    output logic [AW-1:0]   ram_a,
    output logic [DW-1:0]   ram_di,
    input  logic [DW-1:0]   ram_do
);

    localparam int            CW   = $clog2(BURST + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST);

    logic          owner_q, owner_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          rd_own_q, rd_own_d;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;

    logic          win;
    logic          gnt;
    logic          wr;

    always_comb begin
        win = p1_req;
        if (p0_req && p1_req) begin
            if (FIXED_PRI != 0) begin
                win = 1'b0;
            // bcnt==0 means no burst in progress, so contention goes to the port that did not win last
            end else if (bcnt_q != '0 && bcnt_q < BMAX) begin
                win = owner_q;
            end else begin
                win = ~owner_q;
            end
        end
        gnt = (p0_req | p1_req) & ~RST;
        wr  = win ? (|p1_we) : (|p0_we);

        owner_d  = owner_q;
        bcnt_d   = '0;
        rd_own_d = rd_own_q;
        if (gnt) begin
            owner_d  = win;
            rd_own_d = win;
            if (win == owner_q) begin
                bcnt_d = (bcnt_q == BMAX) ? BMAX : bcnt_q + 1'b1;
            end else begin
                bcnt_d = CW'(1);
            end
        end
        p0_rvalid_d = gnt & ~win & ~wr;
        p1_rvalid_d = gnt &  win & ~wr;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            owner_q     <= 1'b1;
            bcnt_q      <= '0;
            rd_own_q    <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            bcnt_q      <= bcnt_d;
            rd_own_q    <= rd_own_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end

    always_comb begin
        p0_gnt    = gnt & ~win;
        p1_gnt    = gnt &  win;
        ram_en    = gnt;
        ram_we    = gnt ? (win ? p1_we    : p0_we)    : '0;
        ram_a     = gnt ? (win ? p1_addr  : p0_addr)  : '0;
        ram_di    = gnt ? (win ? p1_wdata : p0_wdata) : '0;
        p0_rvalid = p0_rvalid_q;
        p1_rvalid = p1_rvalid_q;
        p0_rdata  = (p0_rvalid_q && !rd_own_q) ? ram_do : '0;
        p1_rdata  = (p1_rvalid_q &&  rd_own_q) ? ram_do : '0;
    end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural byte-writable SRAM behind the round-robin instance
// and a second fixed-priority instance sharing the same request inputs.
module tb_ram_arbiter_2p;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [3:0]  p0_we = '0, p1_we = '0;
    logic [11:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;

    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_en;
    logic [31:0] p0_rdata, p1_rdata, ram_di;
    logic [3:0]  ram_we;
    logic [11:0] ram_a;
    logic [31:0] ram_do = '0;

    logic        f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid, f_ram_en;
    logic [31:0] f_p0_rdata, f_p1_rdata, f_ram_di;
    logic [3:0]  f_ram_we;
    logic [11:0] f_ram_a;
    logic [31:0] f_ram_do = '0;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    always #5 CLK = ~CLK;

    ram_arbiter_2p #(.AW(12), .DW(32), .BURST(2), .FIXED_PRI(0)) dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    ram_arbiter_2p #(.AW(12), .DW(32), .BURST(2), .FIXED_PRI(1)) dutf (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
        .ram_en(f_ram_en), .ram_we(f_ram_we), .ram_a(f_ram_a), .ram_di(f_ram_di), .ram_do(f_ram_do)
    );

    // SRAM: registered read port, output zero when not enabled or on a write
    logic [31:0] mem [0:4095];
    always @(posedge CLK) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= (ram_we == 4'b0) ? mem[ram_a] : 32'h0;
        end else begin
            ram_do <= 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g3 [6] = '{0, 0, 1, 1, 0, 0};

        // reset with requests asserted
        p0_req = 1'b1; p1_req = 1'b1; p0_addr = 12'h123; p0_wdata = 32'h12345678; p0_we = 4'hF;
        #1 RST = 1'b1;
        #2;
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_di", ram_di, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        tick();
        RST = 1'b0; p1_req = 1'b0;

        // 1: p0 full write then read of 0x010
        p0_req = 1'b1; p0_we = 4'hF; p0_addr = 12'h010; p0_wdata = 32'hDEADBEEF;
        mid();
        chk("t1_wr_gnt", p0_gnt, 1);
        chk("t1_wr_ram_we", ram_we, 4'hF);
        chk("t1_wr_ram_a", ram_a, 12'h010);
        chk("t1_wr_ram_di", ram_di, 32'hDEADBEEF);
        tick();
        p0_we = 4'h0;
        mid();
        chk("t1_rd_gnt", p0_gnt, 1);
        chk("t1_wr_no_rvalid", p0_rvalid, 0);
        tick();
        p0_req = 1'b0;
        mid();
        chk("t1_rvalid", p0_rvalid, 1);
        chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
        chk("t1_idle_en", ram_en, 0);
        tick();
        mid();
        chk("t1_rvalid_drop", p0_rvalid, 0);
        chk("t1_rdata_zero", p0_rdata, 0);
        tick();

        // 2: p1 partial write of byte 1 then read
        p1_req = 1'b1; p1_we = 4'b0010; p1_addr = 12'h010; p1_wdata = 32'h0000AB00;
        mid();
        chk("t2_wr_gnt", p1_gnt, 1);
        tick();
        p1_we = 4'h0;
        mid();
        chk("t2_rd_gnt", p1_gnt, 1);
        chk("t2_wr_no_rvalid", p1_rvalid, 0);
        tick();
        p1_req = 1'b0;
        mid();
        chk("t2_rvalid", p1_rvalid, 1);
        chk("t2_rdata", p1_rdata, 32'hDEADABEF);
        chk("t2_p0_rvalid", p0_rvalid, 0);
        chk("t2_p0_rdata", p0_rdata, 0);
        tick();

        // 3: contention, BURST=2, all reads
        p0_req = 1'b1; p1_req = 1'b1; p0_we = 4'h0; p1_we = 4'h0;
        p0_addr = 12'h010; p1_addr = 12'h010;
        for (int i = 0; i < 6; i++) begin
            mid();
            chk($sformatf("t3_p0_gnt_%0d", i), p0_gnt, (g3[i] == 0) ? 1 : 0);
            chk($sformatf("t3_p1_gnt_%0d", i), p1_gnt, (g3[i] == 1) ? 1 : 0);
            if (i > 0) begin
                chk($sformatf("t3_p0_rvalid_%0d", i), p0_rvalid, (g3[i-1] == 0) ? 1 : 0);
                chk($sformatf("t3_p1_rvalid_%0d", i), p1_rvalid, (g3[i-1] == 1) ? 1 : 0);
            end
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        mid();
        chk("t3_last_p0_rvalid", p0_rvalid, 1);
        chk("t3_last_p1_rvalid", p1_rvalid, 0);
        chk("t3_last_rdata", p0_rdata, 32'hDEADABEF);
        tick();

        // 4: fixed priority instance
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("t4_p0_gnt_%0d", i), f_p0_gnt, 1);
            chk($sformatf("t4_p1_gnt_%0d", i), f_p1_gnt, 0);
            tick();
        end
        p0_req = 1'b0;
        mid();
        chk("t4_p1_gnt_after", f_p1_gnt, 1);
        chk("t4_p0_gnt_after", f_p0_gnt, 0);
        tick();
        p1_req = 1'b0;
        tick();

        // 6: p0 write 0x7FF immediately followed by p1 read 0x7FF
        p0_req = 1'b1; p0_we = 4'hF; p0_addr = 12'h7FF; p0_wdata = 32'hAAAA5555;
        mid();
        chk("t6_wr_gnt", p0_gnt, 1);
        tick();
        p0_req = 1'b0; p0_we = 4'h0;
        p1_req = 1'b1; p1_we = 4'h0; p1_addr = 12'h7FF;
        mid();
        chk("t6_rd_gnt", p1_gnt, 1);
        tick();
        p1_req = 1'b0;
        mid();
        chk("t6_rvalid", p1_rvalid, 1);
        chk("t6_rdata", p1_rdata, 32'hAAAA5555);
        tick();

        // 5: p1 read 0xFFF then reset before the return completes
        p1_req = 1'b1; p1_we = 4'h0; p1_addr = 12'hFFF;
        mid();
        chk("t5_gnt", p1_gnt, 1);
        chk("t5_ram_a", ram_a, 12'hFFF);
        tick();
        chk("t5_rvalid_pre", p1_rvalid, 1);
        RST = 1'b1;
        #1;
        chk("t5_rst_gnt", p1_gnt, 0);
        chk("t5_rst_en", ram_en, 0);
        chk("t5_rst_rvalid", p1_rvalid, 0);
        tick();
        RST = 1'b0; p1_req = 1'b0;
        mid();
        chk("t5_rel_rvalid", p1_rvalid, 0);
        tick();
        p0_req = 1'b1; p1_req = 1'b1; p0_we = 4'h0; p0_addr = 12'h010; p1_addr = 12'h010;
        mid();
        chk("t5_first_p0", p0_gnt, 1);
        chk("t5_first_p1", p1_gnt, 0);
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
